// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift right / shift left / load, optional rotate) with serialisation counter.
// One-cycle latency on every update; no backpressure, En=0 stalls all state and suppresses Done.
module univ_shift_reg #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             CW        = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic             Rot,
    input  logic             Sin,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Q,
    output logic             Sout_r,
    output logic             Sout_l,
    output logic [CW-1:0]    Cnt,
    output logic             Done
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             fill;
    logic             shifting;

    always_comb begin
        q_d      = q_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        fill     = 1'b0;
        shifting = 1'b0;

        if (En) begin
            case (Mode)
                MODE_HOLD: ;
                MODE_SHR: begin
                    fill     = Rot ? q_q[0] : Sin;
                    q_d      = {fill, q_q[WIDTH-1:1]};
                    shifting = 1'b1;
                end
                MODE_SHL: begin
                    fill     = Rot ? q_q[WIDTH-1] : Sin;
                    q_d      = {q_q[WIDTH-2:0], fill};
                    shifting = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = Din;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end

        // Rotation wraps modulo WIDTH; plain shifts saturate once the word has fully left.
        if (shifting) begin
            if (Rot) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = CW'(1);
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (cnt_q != CNT_MAX) begin
                cnt_d  = cnt_q + 1'b1;
                done_d = (cnt_q == CNT_LAST);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign Q      = q_q;
    assign Sout_r = q_q[0];
    assign Sout_l = q_q[WIDTH-1];
    assign Cnt    = cnt_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed scenarios plus randomized traffic for univ_shift_reg, checked against an arithmetic reference model.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          Clk;
    logic          Rst_n;
    logic          En;
    logic [1:0]    Mode;
    logic          Rot;
    logic          Sin;
    logic [W-1:0]  Din;
    logic [W-1:0]  Q;
    logic          Sout_r;
    logic          Sout_l;
    logic [CW-1:0] Cnt;
    logic          Done;

    int vectors;
    int miscompares;

    // Reference model state: register value, shifts-since-load, pending Done.
    int m_q;
    int m_cnt;
    int m_done;

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .En     (En),
        .Mode   (Mode),
        .Rot    (Rot),
        .Sin    (Sin),
        .Din    (Din),
        .Q      (Q),
        .Sout_r (Sout_r),
        .Sout_l (Sout_l),
        .Cnt    (Cnt),
        .Done   (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_q    = 0;
        m_cnt  = 0;
        m_done = 0;
    endtask

    // Drive one cycle of inputs, advance the model, and return 1 time unit after the edge.
    task automatic cycle(input bit en, input logic [1:0] mode, input bit rot,
                         input bit sin, input logic [W-1:0] din);
        int fill;
        En   = en;
        Mode = mode;
        Rot  = rot;
        Sin  = sin;
        Din  = din;
        m_done = 0;
        if (en && (mode == 2'b01 || mode == 2'b10)) begin
            if (mode == 2'b01) begin
                fill = rot ? (m_q % 2) : int'(sin);
                m_q  = (m_q / 2) + fill * (1 << (W - 1));
            end else begin
                fill = rot ? (m_q / (1 << (W - 1))) : int'(sin);
                m_q  = ((m_q * 2) % (1 << W)) + fill;
            end
            if (rot) begin
                m_cnt  = (m_cnt == W) ? 1 : (m_cnt + 1) % W;
                m_done = (m_cnt == 0);
            end else begin
                m_done = (m_cnt == W - 1);
                m_cnt  = (m_cnt < W) ? m_cnt + 1 : W;
            end
        end else if (en && mode == 2'b11) begin
            m_q   = int'(din);
            m_cnt = 0;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 2'b11, 0, 0, 8'h3C);
        vectors++;
        if (Q !== 8'h3C) begin
            miscompares++;
            $display("FAIL reset_preload: Q=%h expected 3c", Q);
        end
        Rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (Q !== 8'h00 || Cnt !== 4'd0 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: Q=%h Cnt=%0d Done=%b expected 00/0/0", Q, Cnt, Done);
        end
        #2;
        Rst_n = 1'b1;
    endtask

    task automatic test_serialise();
        logic [7:0] exp_q [8];
        logic       exp_sr [8];
        exp_q  = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
        exp_sr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        cycle(1, 2'b11, 0, 0, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (Sout_r !== exp_sr[i]) begin
                miscompares++;
                $display("FAIL shr_sout_r[%0d]: got %b expected %b", i, Sout_r, exp_sr[i]);
            end
            cycle(1, 2'b01, 0, 0, 8'h00);
            vectors++;
            if (Q !== exp_q[i] || int'(Cnt) !== i + 1 || Done !== (i == 7)) begin
                miscompares++;
                $display("FAIL shr_step[%0d]: Q=%h Cnt=%0d Done=%b expected %h/%0d/%b",
                         i, Q, Cnt, Done, exp_q[i], i + 1, (i == 7));
            end
        end
        cycle(1, 2'b01, 0, 0, 8'h00);
        vectors++;
        if (Cnt !== 4'd8 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL shr_saturate: Cnt=%0d Done=%b expected 8/0", Cnt, Done);
        end
    endtask

    task automatic test_rotate();
        int pulses;
        pulses = 0;
        cycle(1, 2'b11, 0, 0, 8'h81);
        cycle(1, 2'b10, 1, 0, 8'h00);
        vectors++;
        if (Q !== 8'h03 || Cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL rot_first: Q=%h Cnt=%0d expected 03/1", Q, Cnt);
        end
        pulses += int'(Done);
        for (int i = 0; i < 7; i++) begin
            cycle(1, 2'b10, 1, 1, 8'h00);
            pulses += int'(Done);
        end
        vectors++;
        if (Q !== 8'h81 || Cnt !== 4'd0 || pulses != 1 || Done !== 1'b1) begin
            miscompares++;
            $display("FAIL rot_full: Q=%h Cnt=%0d pulses=%0d Done=%b expected 81/0/1/1",
                     Q, Cnt, pulses, Done);
        end
    endtask

    task automatic test_enable();
        cycle(1, 2'b11, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1, 2'b10, 0, 1, 8'h00);
        vectors++;
        if (Q !== 8'h07 || Cnt !== 4'd3) begin
            miscompares++;
            $display("FAIL shl_sin: Q=%h Cnt=%0d expected 07/3", Q, Cnt);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(0, 2'b10, 0, 1, 8'hFF);
            vectors++;
            if (Q !== 8'h07 || Cnt !== 4'd3 || Done !== 1'b0) begin
                miscompares++;
                $display("FAIL en_hold[%0d]: Q=%h Cnt=%0d Done=%b expected 07/3/0", i, Q, Cnt, Done);
            end
        end
    endtask

    task automatic test_midload();
        cycle(1, 2'b11, 0, 0, 8'hFF);
        for (int i = 0; i < 5; i++) cycle(1, 2'b01, 0, 0, 8'h00);
        cycle(1, 2'b11, 1, 1, 8'h5A);
        vectors++;
        if (Q !== 8'h5A || Cnt !== 4'd0 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL midload: Q=%h Cnt=%0d Done=%b expected 5a/0/0", Q, Cnt, Done);
        end
    endtask

    task automatic test_hold();
        cycle(1, 2'b01, 0, 1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 2'b00, $urandom_range(0, 1), i[0], 8'hC3);
            vectors++;
            if (Q !== 8'hAD || Cnt !== 4'd1 || Done !== 1'b0) begin
                miscompares++;
                $display("FAIL hold[%0d]: Q=%h Cnt=%0d Done=%b expected ad/1/0", i, Q, Cnt, Done);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] mode;
        int         sel;
        for (int i = 0; i < 400; i++) begin
            sel  = $urandom_range(0, 15);
            mode = (sel == 0) ? 2'b11 : (sel < 3) ? 2'b00 : (sel < 9) ? 2'b01 : 2'b10;
            cycle(($urandom_range(0, 7) != 0), mode, ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 1), W'($urandom));
            vectors++;
            if (int'(Q) !== m_q || int'(Cnt) !== m_cnt || int'(Done) !== m_done ||
                Sout_r !== Q[0] || Sout_l !== Q[W-1]) begin
                miscompares++;
                $display("FAIL random[%0d]: Q=%h Cnt=%0d Done=%b Sout_r=%b Sout_l=%b expected %h/%0d/%0d",
                         i, Q, Cnt, Done, Sout_r, Sout_l, m_q, m_cnt, m_done);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        En    = 1'b0;
        Mode  = 2'b00;
        Rot   = 1'b0;
        Sin   = 1'b0;
        Din   = '0;
        Rst_n = 1'b0;
        model_reset();
        #12;
        vectors++;
        if (Q !== 8'h00 || Cnt !== 4'd0 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: Q=%h Cnt=%0d Done=%b expected 00/0/0", Q, Cnt, Done);
        end
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        test_reset();
        test_serialise();
        test_rotate();
        test_enable();
        test_midload();
        test_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
